// File: rtl/mux_4to1.sv
// Parameterised 4-to-1 multiplexer with an optional registered output stage.
// The valid strobe travels with the selected data; unknown selects yield zero.
module mux_4to1 #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] x,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_data;

    // NOTE: the default arm catches X/Z selects (giving zero) and also keeps
    // sel_data assigned on every path, so no latch is inferred.
    always_comb begin
        case (sel)
            2'b00:   sel_data = a;
            2'b01:   sel_data = b;
            2'b10:   sel_data = c;
            2'b11:   sel_data = d;
            default: sel_data = '0;
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] x_d, x_q;
            logic             out_valid_d, out_valid_q;

            always_comb begin
                x_d         = x_q;
                out_valid_d = in_valid;
                if (in_valid) begin
                    x_d = sel_data;
                end
            end

            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of process order.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q         <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    x_q         <= x_d;
                    out_valid_q <= out_valid_d;
                end
            end

            assign x         = x_q;
            assign out_valid = out_valid_q;
        end else begin : g_comb
            assign x         = sel_data;
            assign out_valid = in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1: 1-bit and 8-bit registered instances checked
// against a scoreboard of model results, plus a combinational instance.
module tb_mux_4to1;

    typedef struct {
        logic [7:0] x1;
        logic [7:0] x8;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] sel = 2'b00;
    logic       in_valid = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, d1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, c8 = '0, d8 = '0;
    logic       x1, v1, v8, vc;
    logic [7:0] x8, xc;

    exp_t       sb[$];
    logic [7:0] held1 = '0, held8 = '0;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    mux_4to1 #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .d(d1),
        .sel(sel), .in_valid(in_valid), .x(x1), .out_valid(v1)
    );

    mux_4to1 #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .d(d8),
        .sel(sel), .in_valid(in_valid), .x(x8), .out_valid(v8)
    );

    mux_4to1 #(.WIDTH(8), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .d(d8),
        .sel(sel), .in_valid(in_valid), .x(xc), .out_valid(vc)
    );

    function automatic logic [7:0] model(input logic [1:0] s, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c,
                                         input logic [7:0] d);
        if ($isunknown(s)) return 8'h00;
        if (s == 2'b00) return a;
        if (s == 2'b01) return b;
        if (s == 2'b10) return c;
        return d;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_push(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input logic v);
        logic [7:0] m;
        exp_t       e;
        sel = s;
        a1 = a[0]; b1 = b[0]; c1 = c[0]; d1 = d[0];
        a8 = a;    b8 = b;    c8 = c;    d8 = d;
        in_valid = v;
        if (v) begin
            m     = model(s, a, b, c, d);
            held1 = {7'b0, m[0]};
            held8 = m;
        end
        e.x1 = held1;
        e.x8 = held8;
        e.v  = v;
        sb.push_back(e);
    endtask

    task automatic edge_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            check({tag, "_x1"}, {7'b0, x1}, e.x1);
            check({tag, "_x8"}, x8, e.x8);
            check({tag, "_v1"}, {7'b0, v1}, {7'b0, e.v});
            check({tag, "_v8"}, {7'b0, v8}, {7'b0, e.v});
        end
    endtask

    task automatic step(input string tag, input logic [1:0] s, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                        input logic v);
        @(negedge clk);
        drive_push(s, a, b, c, d, v);
        edge_check(tag);
    endtask

    initial begin
        // Power-up reset, asserted before the first clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_x1", {7'b0, x1}, 8'h00);
        check("rst_x8", x8, 8'h00);
        check("rst_v", {6'b0, v1, v8}, 8'h00);
        in_valid = 1'b1; a1 = 1'b1; a8 = 8'hff; sel = 2'b00;
        @(posedge clk); #1;
        check("rst_ignore_x1", {7'b0, x1}, 8'h00);
        check("rst_ignore_v", {7'b0, v1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive_push(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        edge_check("idle");

        // Exhaustive truth table on the 1-bit data path
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 16; k++) begin
                step($sformatf("tt_s%0d_k%0d", s, k), 2'(s), {7'b0, k[0]}, {7'b0, k[1]},
                     {7'b0, k[2]}, {7'b0, k[3]}, 1'b1);
            end
        end

        // Latency and hold: one valid pulse, then the output holds
        step("lat_cap", 2'b01, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1);
        step("lat_hold0", 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        step("lat_hold1", 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        check("lat_x1_still1", {7'b0, x1}, 8'h01);

        // Asynchronous reset mid-cycle with a valid value in flight
        @(negedge clk);
        drive_push(2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_x1", {7'b0, x1}, 8'h00);
        check("arst_v1", {7'b0, v1}, 8'h00);
        @(posedge clk); #1;
        check("arst_held_x1", {7'b0, x1}, 8'h00);
        check("arst_held_v1", {7'b0, v1}, 8'h00);
        sb.delete();
        held1 = '0;
        held8 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_push(2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
        edge_check("arst_release");

        // Wide data, back-to-back selections with no bubble
        step("wide_00", 2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        step("wide_01", 2'b01, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        step("wide_10", 2'b10, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        step("wide_11", 2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);

        // Unknown select with all inputs set
        step("sel_x", 2'bx1, 8'hff, 8'hff, 8'hff, 8'hff, 1'b1);

        // Combinational variant: changes between edges show up immediately
        @(negedge clk);
        #1;
        sel = 2'b10; a8 = 8'h55; b8 = 8'h66; c8 = 8'h77; d8 = 8'h88; in_valid = 1'b0;
        #1;
        check("comb_c", xc, 8'h77);
        check("comb_v0", {7'b0, vc}, 8'h00);
        sel = 2'b11; in_valid = 1'b1;
        #1;
        check("comb_d", xc, 8'h88);
        check("comb_v1", {7'b0, vc}, 8'h01);
        d8 = 8'h99; rst_n = 1'b0;
        #1;
        check("comb_d_new_in_rst", xc, 8'h99);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
Parameterised 4-to-1 multiplexer with a registered output stage. One of four equal-width data inputs is selected by a 2-bit select and presented on the output one clock after capture. A valid strobe is carried alongside the data. Used as a generic datapath selector wherever a timing-clean, reset-defined select output is required.

Parameters:
WIDTH, 1, bit width of each data input and of the output.
REG_OUT, 1, 1 = registered output (1-cycle latency); 0 = purely combinational path, and clk/rst_n are unused for data.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
a  input  WIDTH  data input 0, selected when sel = 2'b00.
b  input  WIDTH  data input 1, selected when sel = 2'b01.
c  input  WIDTH  data input 2, selected when sel = 2'b10.
d  input  WIDTH  data input 3, selected when sel = 2'b11.
sel  input  2  input select.
in_valid  input  1  qualifies a/b/c/d/sel for capture.
x  output  WIDTH  selected data.
out_valid  output  1  x holds a freshly captured selection.

Behaviour:
- Select map:
  - 00 -> a
  - 01 -> b
  - 10 -> c
  - 11 -> d
- If sel contains X/Z, the next selection is all-zero. The mux must never propagate X from an unselected input.
- Non-selected inputs have no effect on x, whatever their value.
- REG_OUT = 1:
  - On each rising clk with in_valid = 1: x <= mux(sel, a, b, c, d) and out_valid <= 1.
  - On each rising clk with in_valid = 0: x holds its previous value and out_valid <= 0.
  - Latency is exactly 1 cycle from sampled inputs to x.
  - Throughput is one selection per cycle. Back-to-back valid cycles give back-to-back results with no bubble.
- REG_OUT = 0:
  - x = mux(sel, a, b, c, d) combinationally.
  - out_valid = in_valid combinationally.
  - No state; reset has no effect.
- Reset (REG_OUT = 1):
  - rst_n low asynchronously forces x = 0 and out_valid = 0, independent of clk.
  - The outputs stay at these values while rst_n is low. Inputs are ignored during reset.
  - Release is synchronous to the first rising clk with rst_n high. The first capture occurs on that edge if in_valid = 1.
  - Reset asserted mid-stream discards the in-flight value. No result is produced for the cycle in which reset was asserted.
- Simultaneous change of sel and data in one cycle: the pair sampled at the edge is used.
- Width rules:
  - All data inputs are exactly WIDTH bits.
  - No extension or truncation is performed.
  - WIDTH >= 1 is the only legal setting.

Test Plan:
- Exhaustive truth table, WIDTH = 1, REG_OUT = 1, in_valid = 1: for each sel in 00..11, sweep all 16 (a,b,c,d) combinations at 10 ns spacing. After each edge, x equals the selected input; e.g. sel = 10, a = 1, b = 1, c = 0, d = 1 -> x = 0 next cycle, out_valid = 1.
- Latency/hold: apply sel = 01, b = 1 with in_valid = 1 for one cycle, then in_valid = 0 and b = 0. Required: x = 1 one cycle later, with out_valid pulsing high for exactly one cycle; x stays 1 afterwards.
- Asynchronous reset: with x = 1, drop rst_n mid-cycle. Required: x = 0 and out_valid = 0 immediately, before the next edge. After release with a = 1, sel = 00, in_valid = 1: x = 1 after the first edge.
- Wide data, WIDTH = 8: a = 8'h11, b = 8'h22, c = 8'h33, d = 8'h44, stepping sel through 00, 01, 10, 11 on consecutive cycles. Required: x = 11, 22, 33, 44 on consecutive cycles with no bubbles.
- Unknown select: sel = 2'bx1 with all inputs = 1. Required: x = 0 next cycle.
- Combinational variant, REG_OUT = 0: change sel and data with no clock edge. Required: x follows within the same time step; out_valid mirrors in_valid.
